// File: rtl/step_input_ctrl.sv
// Front-panel input conditioner: tick divider, synchronised sampling, debounce,
// edge / auto-repeat step pulses, lowest-index arbitration and a step counter.
module step_input_ctrl #(
   parameter int NUM_BTN      = 4,
   parameter int SW_WIDTH     = 8,
   parameter int DIV_WIDTH    = 17,
   parameter int DEB_TAPS     = 3,
   parameter int REPEAT_DELAY = 16,
   parameter int REPEAT_RATE  = 4,
   parameter int CNT_WIDTH    = 8,
   localparam int IDX_W       = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_BTN-1:0]   i_btn,
   input  logic [SW_WIDTH-1:0]  i_sw,
   input  logic [1:0]           i_edge_mode,
   input  logic                 i_repeat_en,
   input  logic                 i_cnt_clr,
   output logic                 o_tick,
   output logic [SW_WIDTH-1:0]  o_sw_word,
   output logic [NUM_BTN-1:0]   o_level,
   output logic [NUM_BTN-1:0]   o_step,
   output logic                 o_step_valid,
   output logic [IDX_W-1:0]     o_step_idx,
   output logic [CNT_WIDTH-1:0] o_step_cnt
);

   localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [7:0]           RC_ONE  = 8'd1;
   localparam logic [7:0]           DELAY_L = 8'(REPEAT_DELAY);
   localparam logic [7:0]           RATE_L  = 8'(REPEAT_RATE);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RPT} rpt_state_t;

   logic [DIV_WIDTH-1:0] r_div;
   logic                 r_tick;
   logic [NUM_BTN-1:0]   r_btn_sync1, r_btn_sync2;
   logic [SW_WIDTH-1:0]  r_sw_sync1, r_sw_sync2, r_sw_word;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [NUM_BTN-1:0]   w_level, w_step;
   logic                 w_step_valid;
   logic [IDX_W-1:0]     w_step_idx;
   logic                 w_rpt_allow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_div  <= r_div + DIV_ONE;
         r_tick <= (r_div == '1);
      end
   end

   // Pins are asynchronous to clk, so both go through a 2-FF synchroniser first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_btn_sync1 <= '0;
         r_btn_sync2 <= '0;
         r_sw_sync1  <= '0;
         r_sw_sync2  <= '0;
         r_sw_word   <= '0;
      end else begin
         r_btn_sync1 <= i_btn;
         r_btn_sync2 <= r_btn_sync1;
         r_sw_sync1  <= i_sw;
         r_sw_sync2  <= r_sw_sync1;
         if (r_tick)
            r_sw_word <= r_sw_sync2;
      end
   end

   assign w_rpt_allow = (i_edge_mode != 2'b11);

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic [DEB_TAPS-1:0] r_shift;
      logic                r_lvl, r_lvl_d, r_lvl_tick, r_edge, r_rpt;
      rpt_state_t          r_state;
      logic [7:0]          r_rcnt;
      logic [7:0]          w_rcnt_inc;

      assign w_rcnt_inc = r_rcnt + RC_ONE;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_shift <= '0;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
            r_edge  <= 1'b0;
         end else begin
            if (r_tick)
               r_shift <= {r_shift[DEB_TAPS-2:0], r_btn_sync2[gi]};
            if (&r_shift)
               r_lvl <= 1'b1;
            else if (~|r_shift)
               r_lvl <= 1'b0;
            r_lvl_d <= r_lvl;
            case (i_edge_mode)
               2'b00:   r_edge <= r_lvl & ~r_lvl_d;
               2'b01:   r_edge <= ~r_lvl & r_lvl_d;
               2'b10:   r_edge <= r_lvl ^ r_lvl_d;
               default: r_edge <= 1'b0;
            endcase
         end
      end

      // r_rcnt holds ticks elapsed since the press; the FSM first sees the
      // new level one tick after the press, hence entry with a count of one.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_state    <= ST_IDLE;
            r_rcnt     <= '0;
            r_rpt      <= 1'b0;
            r_lvl_tick <= 1'b0;
         end else begin
            r_rpt <= 1'b0;
            if (r_tick) begin
               r_lvl_tick <= r_lvl;
               if (!r_lvl || !i_repeat_en) begin
                  r_state <= ST_IDLE;
                  r_rcnt  <= '0;
               end else begin
                  case (r_state)
                     ST_IDLE: begin
                        if (!r_lvl_tick) begin
                           if (DELAY_L == RC_ONE) begin
                              r_state <= ST_RPT;
                              r_rcnt  <= '0;
                              r_rpt   <= w_rpt_allow;
                           end else begin
                              r_state <= ST_WAIT;
                              r_rcnt  <= RC_ONE;
                           end
                        end
                     end
                     ST_WAIT: begin
                        if (w_rcnt_inc == DELAY_L) begin
                           r_state <= ST_RPT;
                           r_rcnt  <= '0;
                           r_rpt   <= w_rpt_allow;
                        end else begin
                           r_rcnt <= w_rcnt_inc;
                        end
                     end
                     ST_RPT: begin
                        if (w_rcnt_inc == RATE_L) begin
                           r_rcnt <= '0;
                           r_rpt  <= w_rpt_allow;
                        end else begin
                           r_rcnt <= w_rcnt_inc;
                        end
                     end
                     default: begin
                        r_state <= ST_IDLE;
                        r_rcnt  <= '0;
                     end
                  endcase
               end
            end
         end
      end

      assign w_level[gi] = r_lvl;
      assign w_step[gi]  = r_edge | r_rpt;
   end

   assign w_step_valid = |w_step;

   always_comb begin
      w_step_idx = '0;
      for (int i = NUM_BTN - 1; i >= 0; i--)
         if (w_step[i])
            w_step_idx = IDX_W'(i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (i_cnt_clr)
         r_cnt <= '0;
      else if (w_step_valid)
         r_cnt <= r_cnt + CNT_ONE;
   end

   assign o_tick       = r_tick;
   assign o_sw_word    = r_sw_word;
   assign o_level      = w_level;
   assign o_step       = w_step;
   assign o_step_valid = w_step_valid;
   assign o_step_idx   = w_step_idx;
   assign o_step_cnt   = r_cnt;

endmodule

// File: tb/tb_step_input_ctrl.sv
// Scoreboard bench for step_input_ctrl: a tick-level reference model predicts
// every step pulse, level and switch word; a monitor compares pulses as they appear.
module tb_step_input_ctrl;
   localparam int NB = 4, SW = 8, DW = 4, TAPS = 3, DLY = 4, RATE = 2, CW = 8, IW = 2;
   localparam int PER = 16, MAXT = 1024;

   logic           clk = 1'b0, rst = 1'b1;
   logic [NB-1:0]  i_btn = '0;
   logic [SW-1:0]  i_sw = '0;
   logic [1:0]     i_edge_mode = 2'b00;
   logic           i_repeat_en = 1'b0, i_cnt_clr = 1'b0;
   logic           o_tick, o_step_valid;
   logic [SW-1:0]  o_sw_word;
   logic [NB-1:0]  o_level, o_step;
   logic [IW-1:0]  o_step_idx;
   logic [CW-1:0]  o_step_cnt;

   step_input_ctrl #(
      .NUM_BTN(NB), .SW_WIDTH(SW), .DIV_WIDTH(DW), .DEB_TAPS(TAPS),
      .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .i_btn(i_btn), .i_sw(i_sw), .i_edge_mode(i_edge_mode),
      .i_repeat_en(i_repeat_en), .i_cnt_clr(i_cnt_clr), .o_tick(o_tick),
      .o_sw_word(o_sw_word), .o_level(o_level), .o_step(o_step),
      .o_step_valid(o_step_valid), .o_step_idx(o_step_idx), .o_step_cnt(o_step_cnt)
   );

   always #5 clk = ~clk;

   int cyc;
   always @(posedge clk or posedge rst)
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;

   typedef struct {
      int            cyc;
      logic [NB-1:0] vec;
      logic [IW-1:0] idx;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t          exp_q[$];
   int            checks = 0, failures = 0;
   bit            mon_on = 0;
   logic [NB-1:0] samp [MAXT];
   logic [NB-1:0] lev  [MAXT];
   int            anchor [NB];
   logic [CW-1:0] m_cnt = '0;
   int            tick_j = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, req);
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   function automatic logic [NB-1:0] get_samp(input int k);
      return (k <= 0) ? '0 : samp[k];
   endfunction

   function automatic logic [NB-1:0] get_lev(input int k);
      return (k <= 0) ? '0 : lev[k];
   endfunction

   function automatic logic [IW-1:0] lowest(input logic [NB-1:0] v);
      logic [IW-1:0] r;
      r = '0;
      for (int b = NB - 1; b >= 0; b--)
         if (v[b]) r = IW'(b);
      return r;
   endfunction

   task automatic push_pulse(input int c, input logic [NB-1:0] v, input bit clr);
      exp_t e;
      if (clr)          m_cnt = '0;
      else if (v != 0)  m_cnt = m_cnt + 1'b1;
      if (v != 0) begin
         e.cyc = c; e.vec = v; e.idx = lowest(v); e.cnt = m_cnt;
         exp_q.push_back(e);
      end
   endtask

   // One sample period: drive the pins for tick j, predict its outcome, check level/switches.
   // clr_kind: 0 none, 1 clear in the edge-pulse cycle, 2 clear in a quiet cycle.
   task automatic period(input logic [NB-1:0] btn, input logic [1:0] mode, input bit ren,
                         input logic [SW-1:0] sw, input int clr_kind);
      int            j, e;
      logic [NB-1:0] lp1, lp2, cur, rpt, edg;
      bit            agree, rose, fell;
      tick_j++;
      j = tick_j;
      wait_cyc(PER * (j - 1) + 6);
      i_btn = btn; i_edge_mode = mode; i_repeat_en = ren; i_sw = sw;
      samp[j] = btn;
      lp1 = get_lev(j - 1);
      lp2 = get_lev(j - 2);
      for (int b = 0; b < NB; b++) begin
         agree = 1'b1;
         for (int t = 1; t < TAPS; t++) begin
            cur = get_samp(j - t);
            if (cur[b] != btn[b]) agree = 1'b0;
         end
         lev[j][b] = agree ? btn[b] : lp1[b];
      end
      cur = lev[j];
      rpt = '0;
      edg = '0;
      for (int b = 0; b < NB; b++) begin
         if (!lp1[b] || !ren) anchor[b] = -1;
         else begin
            if (anchor[b] < 0 && !lp2[b]) anchor[b] = j - 1;
            if (anchor[b] >= 0) begin
               e = j - anchor[b];
               if (e == DLY || (e > DLY && (e - DLY) % RATE == 0)) rpt[b] = 1'b1;
            end
         end
         rose = !lp1[b] && cur[b];
         fell = lp1[b] && !cur[b];
         case (mode)
            2'b00:   edg[b] = rose;
            2'b01:   edg[b] = fell;
            2'b10:   edg[b] = rose || fell;
            default: edg[b] = 1'b0;
         endcase
      end
      if (mode == 2'b11) rpt = '0;
      push_pulse(PER * j + 1, rpt, 1'b0);
      push_pulse(PER * j + 3, edg, clr_kind == 1);
      if (clr_kind == 2) m_cnt = '0;
      if (clr_kind == 1) begin
         wait_cyc(PER * j + 3); i_cnt_clr = 1'b1;
      end
      wait_cyc(PER * j + 4);
      i_cnt_clr = 1'b0;
      check("level", o_level, lev[j]);
      check("sw_word", o_sw_word, sw);
      if (clr_kind == 2) begin
         wait_cyc(PER * j + 5); i_cnt_clr = 1'b1;
         wait_cyc(PER * j + 6); i_cnt_clr = 1'b0;
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT shows a step.
   initial begin
      exp_t ex;
      bit            cnt_pend = 0;
      logic [CW-1:0] cnt_exp = '0;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            check("tick", o_tick, (cyc != 0 && cyc % PER == 0));
            if (cnt_pend) begin
               check("step_cnt", o_step_cnt, cnt_exp);
               cnt_pend = 0;
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               checks++; failures++;
               $display("FAIL missing_step cycle=%0d got=none expected=%0h", exp_q[0].cyc, exp_q[0].vec);
               void'(exp_q.pop_front());
            end
            if (o_step_valid) begin
               if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                  ex = exp_q.pop_front();
                  check("step_vec", o_step, ex.vec);
                  check("step_idx", o_step_idx, ex.idx);
                  cnt_pend = 1;
                  cnt_exp  = ex.cnt;
               end else begin
                  checks++; failures++;
                  $display("FAIL unexpected_step cycle=%0d got=%0h expected=none", cyc, o_step);
               end
            end else begin
               check("idle_step", {o_step, o_step_idx}, '0);
            end
         end
      end
   end

   initial begin
      logic [NB-1:0] cur_btn;
      logic [1:0]    cur_mode;
      bit            cur_ren;
      int            ck;
      for (int k = 0; k < MAXT; k++) begin samp[k] = '0; lev[k] = '0; end
      for (int b = 0; b < NB; b++) anchor[b] = -1;
      repeat (3) @(negedge clk);
      check("reset_hold", {o_tick, o_sw_word, o_level, o_step, o_step_valid, o_step_idx, o_step_cnt}, '0);
      rst = 1'b0;
      mon_on = 1;
      for (int c = 1; c <= 15; c++) begin
         wait_cyc(c);
         check("reset_zero", {o_tick, o_sw_word, o_level, o_step, o_step_valid, o_step_idx, o_step_cnt}, '0);
      end
      period('0, 2'b00, 1'b0, '0, 0);
      // Clean press of button 0, rise mode, no repeat.
      repeat (5) period(4'b0001, 2'b00, 1'b0, 8'($urandom), 0);
      repeat (4) period(4'b0000, 2'b00, 1'b0, 8'($urandom), 0);
      // Bouncing button 1, then a stable hold.
      for (int k = 0; k < 6; k++) period((k % 2) ? 4'b0010 : 4'b0000, 2'b00, 1'b0, 8'($urandom), 0);
      repeat (5) period(4'b0010, 2'b00, 1'b0, 8'($urandom), 0);
      repeat (4) period(4'b0000, 2'b00, 1'b0, 8'($urandom), 0);
      // Both-edge mode, then pulses disabled.
      repeat (5) period(4'b0100, 2'b10, 1'b0, 8'($urandom), 0);
      repeat (4) period(4'b0000, 2'b10, 1'b0, 8'($urandom), 0);
      repeat (5) period(4'b0100, 2'b11, 1'b0, 8'($urandom), 0);
      repeat (4) period(4'b0000, 2'b11, 1'b0, 8'($urandom), 0);
      // Auto-repeat on a long hold of button 3.
      repeat (20) period(4'b1000, 2'b00, 1'b1, 8'($urandom), 0);
      repeat (5) period(4'b0000, 2'b00, 1'b1, 8'($urandom), 0);
      // Simultaneous press with a clear in the pulse cycle, then a quiet clear.
      for (int k = 0; k < 5; k++) period(4'b0101, 2'b00, 1'b0, 8'($urandom), (k == 2) ? 1 : 0);
      repeat (4) period(4'b0000, 2'b00, 1'b0, 8'($urandom), 0);
      period(4'b0000, 2'b00, 1'b0, 8'($urandom), 2);
      // Staggered toggles give one edge per tick, carrying the counter through its wrap.
      for (int k = 0; k < 290; k++) begin
         for (int b = 0; b < NB; b++) cur_btn[b] = ((k + b) / 4) % 2 == 1;
         period(cur_btn, 2'b10, 1'b0, 8'($urandom), 0);
      end
      // Random traffic.
      cur_btn = '0; cur_mode = 2'b00; cur_ren = 1'b1;
      for (int k = 0; k < 200; k++) begin
         for (int b = 0; b < NB; b++) if ($urandom_range(0, 3) == 0) cur_btn[b] = ~cur_btn[b];
         if ($urandom_range(0, 9) == 0) cur_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) cur_ren = ~cur_ren;
         ck = $urandom_range(0, 29);
         period(cur_btn, cur_mode, cur_ren, 8'($urandom), (ck == 0) ? 1 : (ck == 1) ? 2 : 0);
      end
      repeat (3) period(4'b0000, 2'b00, 1'b0, 8'($urandom), 0);
      repeat (5) period(4'b1111, 2'b11, 1'b0, 8'($urandom), 0);
      wait_cyc(PER * tick_j + 20);
      check("queue_empty", exp_q.size(), 0);
      mon_on = 0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async_reset", {o_tick, o_sw_word, o_level, o_step, o_step_valid, o_step_idx, o_step_cnt}, '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
